// File: rtl/mips_abb_pkg.sv
// ---------------------------------------------------------------------------
// mips_abb_pkg -- shared types and constants for the EXE-stage multiplier.
//   WIDTH_REG : architectural register width
//   MUL_CNT_W : width of the multiplier step counter for WIDTH_REG operands
//   mul_state : multiplier controller FSM states (IDLE / RUN / DONE)
// Optional feature macro used by the multiplier: EXE_MUL_EARLY_EXIT_EN.
// ---------------------------------------------------------------------------
package mips_abb_pkg;

    localparam int WIDTH_REG = 32;
    localparam int MUL_CNT_W = $clog2(WIDTH_REG);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state;

endpackage

// File: rtl/exe_mul_ctrl_if.sv
// ---------------------------------------------------------------------------
// exe_mul_ctrl_if -- EXE <-> multiplier handshake bundle.
//   mul_i_start  : multiply request (ALU_MUL sitting in EXE)
//   mul_i_src1   : multiplicand
//   mul_i_src2   : multiplier
//   mul_i_flush  : abort current operation
//   mul_o_stall  : freeze IF/ID/EXE pipeline registers
//   mul_o_valid  : one-cycle product-ready strobe
//   mul_o_res    : product low word
//   mul_o_res_hi : product high word
//   mul_o_busy   : multiplier iterating
// master = EXE stage side, slave = multiplier side.
// ---------------------------------------------------------------------------
interface exe_mul_ctrl_if
    import mips_abb_pkg::*;
#(
    parameter int MUL_W = WIDTH_REG
);
    logic             mul_i_start;
    logic [MUL_W-1:0] mul_i_src1;
    logic [MUL_W-1:0] mul_i_src2;
    logic             mul_i_flush;
    logic             mul_o_stall;
    logic             mul_o_valid;
    logic [MUL_W-1:0] mul_o_res;
    logic [MUL_W-1:0] mul_o_res_hi;
    logic             mul_o_busy;

    modport master (
        output mul_i_start, mul_i_src1, mul_i_src2, mul_i_flush,
        input  mul_o_stall, mul_o_valid, mul_o_res, mul_o_res_hi, mul_o_busy
    );

    modport slave (
        input  mul_i_start, mul_i_src1, mul_i_src2, mul_i_flush,
        output mul_o_stall, mul_o_valid, mul_o_res, mul_o_res_hi, mul_o_busy
    );
endinterface

// File: rtl/exe_mul_ctrl.sv
// ---------------------------------------------------------------------------
// exe_mul_ctrl -- iterative shift-and-add unsigned multiplier for EXE.
//   clk : clock, all state on rising edge
//   rst : synchronous active-high reset
//   mul : exe_mul_ctrl_if.slave (start/src1/src2/flush in,
//         stall/valid/res/res_hi/busy out)
// One RUN cycle per multiplier bit; the product is registered on entry to
// DONE, strobed with mul_o_valid for that one cycle, and held until the next
// completed product. EXE selects mul_o_res for ALU_MUL.
// Optional: define EXE_MUL_EARLY_EXIT_EN to leave RUN as soon as the
// remaining multiplier bits are all zero.
// ---------------------------------------------------------------------------
module exe_mul_ctrl
    import mips_abb_pkg::*;
#(
    parameter int MUL_W = WIDTH_REG
) (
    input  logic          clk,
    input  logic          rst,
    exe_mul_ctrl_if.slave mul
);

    localparam int CNT_W = (MUL_W > 1) ? $clog2(MUL_W) : 1;

    mul_state               state;
    logic [2*MUL_W-1:0]     mcand;
    logic [2*MUL_W-1:0]     acc;
    logic [MUL_W-1:0]       mplier;
    logic [CNT_W-1:0]       cnt;
    logic [MUL_W-1:0]       res_q;
    logic [MUL_W-1:0]       res_hi_q;
    logic                   valid_q;
    logic                   busy_q;

    logic [2*MUL_W-1:0]     acc_nxt;
    logic [MUL_W-1:0]       mplier_nxt;
    logic                   last;

    always_comb begin
        acc_nxt    = acc + (mplier[0] ? mcand : '0);
        mplier_nxt = mplier >> 1;
        last       = (cnt == CNT_W'(MUL_W - 1));
`ifdef EXE_MUL_EARLY_EXIT_EN
        // Nothing left to add once the remaining multiplier bits are zero.
        last       = last | (mplier_nxt == '0);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mcand    <= '0;
            acc      <= '0;
            mplier   <= '0;
            cnt      <= '0;
            res_q    <= '0;
            res_hi_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (mul.mul_i_start && !mul.mul_i_flush) begin
                        mcand  <= {{MUL_W{1'b0}}, mul.mul_i_src1};
                        mplier <= mul.mul_i_src2;
                        acc    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (mul.mul_i_flush) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        acc    <= acc_nxt;
                        mcand  <= mcand << 1;
                        mplier <= mplier_nxt;
                        cnt    <= cnt + 1'b1;
                        if (last) begin
                            // Product registered here so it is stable for
                            // the whole DONE cycle and beyond.
                            res_q    <= acc_nxt[MUL_W-1:0];
                            res_hi_q <= acc_nxt[2*MUL_W-1:MUL_W];
                            valid_q  <= 1'b1;
                            busy_q   <= 1'b0;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    // start is still high here for the same instruction;
                    // always go back to IDLE so it cannot retrigger.
                    state <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Stall must rise in the same cycle the request appears, so it is
    // decoded from state rather than registered. Low in DONE lets EXE move.
    assign mul.mul_o_stall  = !rst &&
                              (((state == IDLE) && mul.mul_i_start && !mul.mul_i_flush) ||
                               (state == RUN));
    assign mul.mul_o_valid  = valid_q;
    assign mul.mul_o_res    = res_q;
    assign mul.mul_o_res_hi = res_hi_q;
    assign mul.mul_o_busy   = busy_q;

endmodule

// File: tb/tb_exe_mul_ctrl.sv
// ---------------------------------------------------------------------------
// tb_exe_mul_ctrl -- self-checking bench for exe_mul_ctrl (MUL_W = 32).
// Table of operand/product records driven through the EXE handshake, a
// scoreboard queue of expected products checked whenever mul_o_valid fires,
// and hand-written flush / reset / src2-change sequences.
// Expected latency follows EXE_MUL_EARLY_EXIT_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_exe_mul_ctrl;
    import mips_abb_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exe_mul_ctrl_if #(.MUL_W(W)) mif ();

    exe_mul_ctrl #(.MUL_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .mul (mif)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
    } vec_t;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } prod_t;

    prod_t sb[$];
    int    checks = 0;
    int    passes = 0;
    logic [W-1:0] last_lo = '0;
    logic [W-1:0] last_hi = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic int exp_lat(input logic [W-1:0] b);
        int hb;
        hb = 0;
        for (int i = 0; i < W; i++) if (b[i]) hb = i;
`ifdef EXE_MUL_EARLY_EXIT_EN
        return hb + 2;
`else
        return (hb >= 0) ? W + 1 : W + 1;
`endif
    endfunction

    // Scoreboard: every product strobe must match the oldest pending request.
    always @(negedge clk) begin
        if (rst === 1'b0 && mif.mul_o_valid === 1'b1) begin
            prod_t e;
            if (sb.size() == 0) begin
                check("unexpected_valid", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("sb_res_lo", 64'(mif.mul_o_res), 64'(e.lo));
                check("sb_res_hi", 64'(mif.mul_o_res_hi), 64'(e.hi));
                last_lo = e.lo;
                last_hi = e.hi;
            end
        end
    end

    // Issue one multiply with start held until the DONE cycle ends.
    // chg: rewrite src2 to 9 mid-RUN (product must use the latched value).
    task automatic mul_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit chg);
        int cyc;
        int stalls;
        int lat;
        bit got;
        cyc = 0; stalls = 0; got = 0;
        lat = exp_lat(b);
        @(posedge clk); #1;
        mif.mul_i_src1  = a;
        mif.mul_i_src2  = b;
        mif.mul_i_start = 1'b1;
        sb.push_back(prod_t'(64'(a) * 64'(b)));
        while (!got && cyc <= W + 10) begin
            @(negedge clk);
            if (mif.mul_o_stall) stalls++;
            if (cyc == 1) check("busy_in_run", 64'(mif.mul_o_busy), 64'd1);
            if (mif.mul_o_valid) got = 1;
            else begin
                @(posedge clk); #1;
                cyc++;
                if (chg && cyc == 3) mif.mul_i_src2 = 9;
            end
        end
        check("latency", 64'(cyc), 64'(lat));
        check("stall_cycles", 64'(stalls), 64'(lat));
        @(posedge clk); #1;
        mif.mul_i_start = 1'b0;
        @(negedge clk);
        check("post_done_quiet",
              {61'd0, mif.mul_o_valid, mif.mul_o_busy, mif.mul_o_stall}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        prod_t p;
        logic [W-1:0] base_a;
        logic [W-1:0] base_b;

        vecs[0] = '{a: 32'd3,          b: 32'd5,          lo: 32'd15,         hi: 32'd0};
        vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  lo: 32'h0000_0001,  hi: 32'hFFFF_FFFE};
        vecs[2] = '{a: 32'd0,          b: 32'd12345,      lo: 32'd0,          hi: 32'd0};
        vecs[3] = '{a: 32'd12345,      b: 32'd0,          lo: 32'd0,          hi: 32'd0};
        vecs[4] = '{a: 32'd1,          b: 32'd1,          lo: 32'd1,          hi: 32'd0};
        vecs[5] = '{a: 32'h8000_0000,  b: 32'd2,          lo: 32'd0,          hi: 32'd1};
        vecs[6] = '{a: 32'd7,          b: 32'd2,          lo: 32'd14,         hi: 32'd0};
        base_a = 32'hDEAD_BEEF;
        base_b = 32'h1234_5678;
        p = prod_t'(64'(base_a) * 64'(base_b));
        vecs[7] = '{a: base_a, b: base_b, lo: p.lo, hi: p.hi};

        // Reset, with start asserted to show it is ignored.
        rst = 1'b1;
        mif.mul_i_start = 1'b1;
        mif.mul_i_flush = 1'b0;
        mif.mul_i_src1  = 32'd11;
        mif.mul_i_src2  = 32'd13;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("stall_during_reset", 64'(mif.mul_o_stall), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mif.mul_i_start = 1'b0;
        @(negedge clk);
        check("reset_ctrl", {61'd0, mif.mul_o_valid, mif.mul_o_busy, mif.mul_o_stall}, 64'd0);
        check("reset_res", {mif.mul_o_res_hi, mif.mul_o_res}, 64'd0);

        // Table-driven products.
        foreach (vecs[i]) begin
            mul_op(vecs[i].a, vecs[i].b, 1'b0);
            check("held_res_lo", 64'(mif.mul_o_res), 64'(vecs[i].lo));
            check("held_res_hi", 64'(mif.mul_o_res_hi), 64'(vecs[i].hi));
        end

        // src2 rewritten mid-RUN, start held through DONE.
        mul_op(32'd6, 32'd10, 1'b1);
        check("latched_src2_lo", 64'(mif.mul_o_res), 64'd60);

        // Flush at N+10: idle at N+11, no strobe, result untouched.
        @(posedge clk); #1;
        mif.mul_i_src1  = 32'h1234;
        mif.mul_i_src2  = 32'h8000_0001;
        mif.mul_i_start = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        mif.mul_i_flush = 1'b1;
        @(posedge clk); #1;
        mif.mul_i_flush = 1'b0;
        mif.mul_i_start = 1'b0;
        @(negedge clk);
        check("flush_ctrl", {61'd0, mif.mul_o_valid, mif.mul_o_busy, mif.mul_o_stall}, 64'd0);
        check("flush_res", {mif.mul_o_res_hi, mif.mul_o_res}, {last_hi, last_lo});
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("flush_res_later", {mif.mul_o_res_hi, mif.mul_o_res}, {last_hi, last_lo});

        // Reset at N+5 mid-operation, new multiply at N+7.
        @(posedge clk); #1;
        mif.mul_i_src1  = 32'h55;
        mif.mul_i_src2  = 32'h77;
        mif.mul_i_start = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(negedge clk);
        check("stall_mid_reset", 64'(mif.mul_o_stall), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mif.mul_i_start = 1'b0;
        last_lo = '0;
        last_hi = '0;
        @(negedge clk);
        check("midreset_ctrl", {61'd0, mif.mul_o_valid, mif.mul_o_busy, mif.mul_o_stall}, 64'd0);
        check("midreset_res", {mif.mul_o_res_hi, mif.mul_o_res}, 64'd0);
        mul_op(32'd1000, 32'd3000, 1'b0);
        check("after_reset_res", 64'(mif.mul_o_res), 64'd3000000);

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/exe_mul_ctrl.md
EXE_MUL_CTRL -- requirements
Module: exe_mul_ctrl

Interface
REQ-001 SHALL have parameter MUL_W, default WIDTH_REG (32), meaning operand width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port mul_i_start, input, 1, multiply request from EXE; high while an ALU_MUL instruction sits in EXE.
REQ-005 SHALL have port mul_i_src1, input, MUL_W, multiplicand.
REQ-006 SHALL have port mul_i_src2, input, MUL_W, multiplier.
REQ-007 SHALL have port mul_i_flush, input, 1, abort of the current operation.
REQ-008 SHALL have port mul_o_stall, output, 1, freezes IF/ID/EXE pipeline registers.
REQ-009 SHALL have port mul_o_valid, output, 1, one-cycle product-ready strobe.
REQ-010 SHALL have port mul_o_res, output, MUL_W, product low word.
REQ-011 SHALL have port mul_o_res_hi, output, MUL_W, product high word.
REQ-012 SHALL have port mul_o_busy, output, 1, high in RUN.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-014 SHALL, in IDLE with mul_i_start=1 at cycle N, latch src1 (zero-extended to 2*MUL_W), latch src2, clear the accumulator and counter, and enter RUN at N+1.
REQ-015 SHALL, in each RUN cycle, add the multiplicand to the accumulator if multiplier[0]=1, then shift the multiplicand left 1, shift the multiplier right 1 and increment the counter.
REQ-016 SHALL perform unsigned arithmetic with a 2*MUL_W-bit accumulator and no overflow loss.
REQ-017 SHALL leave RUN for DONE after the RUN cycle in which counter=MUL_W-1, giving MUL_W RUN cycles (N+1..N+MUL_W).
REQ-018 SHALL, in DONE, drive mul_o_valid=1 for exactly one cycle, present mul_o_res/mul_o_res_hi as registered and stable, and return to IDLE on the next cycle.
REQ-019 SHALL, with default latency, assert mul_o_valid at N+MUL_W+1.
REQ-020 SHALL drive mul_o_stall combinationally high in IDLE when mul_i_start=1 and throughout RUN, and low in DONE, so EXE advances at the end of DONE.
REQ-021 SHALL ignore mul_i_start in RUN and DONE; the same instruction still present in DONE SHALL NOT retrigger.
REQ-022 SHALL, on mul_i_flush in any state, enter IDLE next cycle with no mul_o_valid; flush has priority over start and over the DONE strobe.
REQ-023 SHALL hold mul_o_res/mul_o_res_hi until the next product is written in DONE; flush SHALL NOT alter them.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, enter IDLE and clear the accumulator, counter, mul_o_res and mul_o_res_hi to 0, with mul_o_valid=0, mul_o_busy=0 and mul_o_stall=0 (mul_i_start is ignored during reset); this applies mid-operation too.
REQ-025 SHALL give rst priority over mul_i_flush and mul_i_start.

Configuration
REQ-026 SHALL, with macro EXE_MUL_EARLY_EXIT_EN defined, also leave RUN for DONE after any RUN cycle whose shifted multiplier is 0, so there is at least one RUN cycle and latency = position of the highest set bit of src2 + 2 cycles.
REQ-027 SHALL, with EXE_MUL_EARLY_EXIT_EN undefined, have a fixed latency of MUL_W+1 cycles and no early-exit logic synthesized.

Structure
REQ-028 SHALL declare the typedef mul_state (IDLE/RUN/DONE) and the constant MUL_CNT_W = $clog2(WIDTH_REG) in mips_abb_pkg.
REQ-029 SHALL be a single module with no sub-module; EXE selects mul_o_res for ALU_MUL in place of the combinational product.

Verification
REQ-030 SHALL verify: start at N with src1=3, src2=5 -> stall high N..N+32, valid at N+33, res=15, res_hi=0.
REQ-031 SHALL verify: src1=src2=0xFFFFFFFF -> res=0x00000001, res_hi=0xFFFFFFFE.
REQ-032 SHALL verify: flush at N+10 -> IDLE at N+11, stall low at N+11, no valid, res unchanged.
REQ-033 SHALL verify: rst at N+5 -> all outputs 0 at N+6; a new start at N+7 completes with a correct product.
REQ-034 SHALL verify: src2 changed to 9 during RUN and start held through DONE -> one valid only, product uses the latched src2.
REQ-035 SHALL verify: with EXE_MUL_EARLY_EXIT_EN, src1=7, src2=2 -> valid at N+3, res=14; without the macro, valid at N+33.
